// File: rtl/taylor_operand_dispatcher.sv
// rtl/taylor_operand_dispatcher.sv - operand FIFO and start/complete sequencer for the series-evaluation accelerator
//
// Purpose: buffers x operands, issues one accelerator run per operand with the
// operand held stable for the whole run, and captures each result into an
// output register with a valid/ack handshake. Runs are strictly serialised.
//
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    operand push handshake, in_data is the operand
//   acc_start, acc_x     one-cycle start pulse and held operand to accelerator
//   acc_ready            accelerator idle flag (low while it is running)
//   acc_result           accelerator result, valid once acc_ready returns high
//   out_valid/out_ack    result handshake, out_data is the captured result
//   busy                 sequencer active or operands still queued

module taylor_operand_dispatcher #(
    parameter int DATA_W = 16,
    parameter int RES_W  = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              acc_start,
    output logic [DATA_W-1:0] acc_x,
    input  logic              acc_ready,
    input  logic [RES_W-1:0]  acc_result,
    output logic              out_valid,
    output logic [RES_W-1:0]  out_data,
    input  logic              out_ack,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, WAIT_LO, WAIT_HI, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              push;
    logic              pop;
    logic              capture;

    // Readiness comes from the registered count only, so a full FIFO refuses
    // a push even in a cycle where the sequencer pops.
    assign in_ready  = (count != FULL);
    assign push      = in_valid & in_ready;
    assign acc_start = (state == START);
    assign busy      = (state != IDLE) || (count != '0);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                // Waiting for acc_ready also covers a reset that landed while
                // the accelerator was still mid-run.
                if ((count != '0) && acc_ready) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!acc_ready) begin
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (acc_ready) begin
                    if (!out_valid || out_ack) begin
                        capture    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                // The accelerator sits idle here, so acc_result is still the
                // result of this run when the consumer finally acks.
                if (out_ack) begin
                    capture    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc_x     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                acc_x  <= mem[rd_ptr];
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A capture wins over a same-cycle ack so the output never bubbles.
            if (capture) begin
                out_data  <= acc_result;
                out_valid <= 1'b1;
            end else if (out_ack) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Storage is not cleared by reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: doc/taylor_operand_dispatcher.md
# taylor_operand_dispatcher

Upstream feeder for the series-evaluation accelerator (the block driven by `controllerQ`). It buffers incoming x operands in a small FIFO, issues one start to the accelerator per operand, and keeps the operand stable for the whole run. It detects completion from the accelerator's `ready` line and captures the result into an output register with a valid/ack handshake. Evaluations are strictly serialised: one accelerator run at a time, results in operand order.

## Interface
- `DATA_W`, 16: width of the x operand and of `acc_x`.
- `RES_W`, 16: width of the accelerator result and of `out_data`.
- `DEPTH`, 4: operand FIFO depth; power of two, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid` in 1: upstream operand valid.
- `in_data` in DATA_W: upstream operand x.
- `in_ready` out 1: FIFO not full; push occurs when `in_valid & in_ready`.
- `acc_start` out 1: start pulse to accelerator.
- `acc_x` out DATA_W: operand presented to accelerator datapath.
- `acc_ready` in 1: accelerator `ready`. High in accelerator idle, low from its init state until it returns to idle.
- `acc_result` in RES_W: accelerator result register; valid when `acc_ready` rises.
- `out_valid` out 1: result register holds an unconsumed result.
- `out_data` out RES_W: captured result.
- `out_ack` in 1: downstream consumes result when `out_valid & out_ack`.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.

## Operation
- **FIFO**
  - Circular buffer with rd/wr pointers of log2(DEPTH) bits, wrapping modulo DEPTH, plus a count of log2(DEPTH)+1 bits.
  - `in_ready` = (count != DEPTH), derived from registered count. There is no bypass: a push into an empty FIFO becomes poppable the next cycle.
  - Push and pop in the same cycle leave count unchanged. When full, a push is refused even if a pop occurs that cycle.
- **FSM states:** IDLE, START, WAIT_LO, WAIT_HI, HOLD.
  - IDLE: if FIFO non-empty and `acc_ready`=1, pop the head into the `acc_x` register and go to START.
  - START: `acc_start`=1 for exactly this one cycle, then go to WAIT_LO.
  - WAIT_LO: stay until `acc_ready`=0, then go to WAIT_HI.
  - WAIT_HI: stay until `acc_ready`=1.
    - On that cycle, if `out_valid`=0 or `out_ack`=1, load `out_data`←`acc_result`, set `out_valid`, and go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: on `out_ack`=1, load `out_data`←`acc_result` (the accelerator is idle, so the result is stable), keep `out_valid`=1, and go to IDLE.
- **Operand stability:** `acc_x` changes only on an IDLE pop. It is held from START through WAIT_HI/HOLD, covering the accelerator's load state.
- **Output register:** `out_valid` clears on ack unless a capture occurs in the same cycle; a simultaneous ack and capture leaves `out_valid`=1 with the new data.
- **No arithmetic** is performed on operands or results; widths pass through unchanged.

## Timing
- **Reset values:** `in_ready`=1, `acc_start`=0, `acc_x`=0, `out_valid`=0, `out_data`=0, `busy`=0, FSM=IDLE, pointers and count=0. FIFO contents are not cleared.
- **Reset mid-operation:** discards FIFO contents, any in-flight run's result, and any pending output. The accelerator is not reset by this block; after reset the FSM waits in IDLE for `acc_ready`=1 before issuing again.
- **Issue latency:**
  - Operand pushed at cycle n into an empty FIFO in IDLE with `acc_ready`=1: pop at n+1, `acc_start` high at n+2.
  - `out_valid` rises the cycle after the first cycle `acc_ready` is sampled high in WAIT_HI.
- **Start pulse:** `acc_start` is one cycle wide, never asserted outside START, and never reasserted before `acc_ready` has been seen low and then high again.
- **Back-to-back runs:** the next operand is popped no earlier than the cycle after return to IDLE, so at most one run is in flight.
- **Output hold:** `out_data` is stable while `out_valid`=1 and `out_ack`=0.

## Test plan
- **Single operand:** reset, push x=0x0100; accelerator model drops `acc_ready` 1 cycle after start, raises it 20 cycles later with result 0x1234 → exactly one `acc_start` pulse, `acc_x`=0x0100 stable throughout, `out_valid`=1 with `out_data`=0x1234.
- **FIFO full:** push 5 operands 0x1..0x5 while the accelerator is held busy → `in_ready`=0 after the 4th push, 5th refused; results later emerge in order 0x1..0x4.
- **Output backpressure:** `out_ack` held 0 across two completions (results 0xAAAA, 0xBBBB) → `out_data`=0xAAAA held, FSM in HOLD; on ack → `out_data`=0xBBBB next cycle, `out_valid` stays 1, third start issues only after HOLD exits.
- **Simultaneous ack and capture:** `out_ack`=1 on the same cycle `acc_ready` rises → no bubble, `out_valid` stays 1, new data loaded.
- **Reset mid-run:** assert `rst` in WAIT_HI with 2 operands queued → all outputs return to reset values next cycle; no further `acc_start` until a new push arrives and `acc_ready`=1.
- **Push/pop same cycle at count=1:** count remains 1, pointers advance and wrap correctly after 4+ operations.
